// File: rtl/fetch_unit_pkg.sv
// Shared constants, stage-register control encoding and address helpers
// for the instruction-fetch front end and the pipeline registers after it.
package fetch_unit_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 32;

    localparam logic [INST_BUS-1:0]      ZERO_WORD    = 32'h0000_0000;
    localparam logic                     CHIP_ENABLE  = 1'b1;
    localparam logic                     CHIP_DISABLE = 1'b0;
    localparam logic [INST_ADDR_BUS-1:0] RESET_PC     = 32'h0000_0000;
    localparam logic [INST_ADDR_BUS-1:0] PC_STEP      = 32'd4;

    // What a pipeline stage register does on the next edge.
    typedef enum logic [1:0] {
        STAGE_CAPTURE = 2'd0,
        STAGE_HOLD    = 2'd1,
        STAGE_BUBBLE  = 2'd2
    } stage_op_t;

    // Every redirect target is forced onto a word boundary.
    function automatic logic [INST_ADDR_BUS-1:0] word_align(
        input logic [INST_ADDR_BUS-1:0] addr
    );
        return addr & ~(INST_ADDR_BUS'(3));
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// Generic stage register with capture / hold / bubble control.
// A bubble keeps the PC tag (so later stages can still see where it sat)
// but zeroes the instruction and clears valid.
module fetch_unit_if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter int AW = INST_ADDR_BUS,
    parameter int DW = INST_BUS
) (
    input  logic          clk,
    input  logic          rst,
    input  stage_op_t     op,
    input  logic [AW-1:0] pc,
    input  logic [DW-1:0] inst,
    output logic [AW-1:0] id_pc,
    output logic [DW-1:0] id_inst,
    output logic          id_valid
);

    // Stage contents: cleared by reset, otherwise updated according to op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc    <= '0;
            id_inst  <= '0;
            id_valid <= 1'b0;
        end else begin
            case (op)
                STAGE_CAPTURE: begin
                    id_pc    <= pc;
                    id_inst  <= inst;
                    id_valid <= 1'b1;
                end
                STAGE_BUBBLE: begin
                    id_pc    <= pc;
                    id_inst  <= '0;
                    id_valid <= 1'b0;
                end
                default: begin
                    id_pc    <= id_pc;
                    id_inst  <= id_inst;
                    id_valid <= id_valid;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the combinational ROM
// and loads the returned word with its PC into the IF/ID register.
// rom_addr_o and rom_ce_o come straight from flops, so no input reaches
// them combinationally.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if_i,
    input  logic        stall_id_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic [31:0] rom_addr_o,
    output logic        rom_ce_o,
    input  logic [31:0] rom_data_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    logic [INST_ADDR_BUS-1:0] pc;
    logic [INST_ADDR_BUS-1:0] next_pc;
    logic                     ce;
    logic                     stall_pc;
    stage_op_t                if_id_op;

    // stall_id implies the PC must hold too, even if stall_if is low.
    assign stall_pc = stall_if_i | stall_id_i;

    // PC and chip-enable registers; the PC only moves once ce is already on,
    // so the first edge after reset just turns the ROM on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
            ce <= CHIP_DISABLE;
        end else begin
            ce <= CHIP_ENABLE;
            if (ce == CHIP_ENABLE) begin
                pc <= next_pc;
            end
        end
    end

    // Next-PC select: flush over stall over branch over sequential.
    // A stalled branch is simply ignored; ID keeps requesting until accepted.
    always_comb begin
        next_pc = pc + PC_STEP;
        if (flush_i) begin
            next_pc = word_align(flush_pc_i);
        end else if (stall_pc) begin
            next_pc = pc;
        end else if (branch_flag_i) begin
            next_pc = word_align(branch_target_i);
        end
    end

    // IF/ID control: flush, then ID stall (hold), then IF stall, ROM off,
    // and squashed delay slot all insert a bubble; otherwise capture.
    always_comb begin
        if_id_op = STAGE_CAPTURE;
        if (flush_i) begin
            if_id_op = STAGE_BUBBLE;
        end else if (stall_id_i) begin
            if_id_op = STAGE_HOLD;
        end else if (stall_if_i) begin
            if_id_op = STAGE_BUBBLE;
        end else if (ce == CHIP_DISABLE) begin
            if_id_op = STAGE_BUBBLE;
        end else if (branch_flag_i && (DELAY_SLOT == 0)) begin
            if_id_op = STAGE_BUBBLE;
        end
    end

    fetch_unit_if_id_reg #(
        .AW (INST_ADDR_BUS),
        .DW (INST_BUS)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .op       (if_id_op),
        .pc       (pc),
        .inst     (rom_data_i),
        .id_pc    (id_pc_o),
        .id_inst  (id_inst_o),
        .id_valid (id_valid_o)
    );

    assign rom_addr_o = pc;
    assign rom_ce_o   = ce;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (delay slot kept / squashed, different
// reset PCs) driven by the same inputs, each with its own ROM model.
module tb_fetch_unit;

    typedef struct {
        logic        sif;
        logic        sid;
        logic        br;
        logic [31:0] tgt;
        logic        fl;
        logic [31:0] fpc;
    } in_t;

    typedef struct {
        in_t         in;
        logic [31:0] e_addr;
        logic [31:0] e_idpc;
        logic [31:0] e_inst;
        logic        e_valid;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic [31:0] id_pc;
        logic [31:0] id_inst;
        logic        id_valid;
    } mstate_t;

    localparam logic [31:0] RPC_A = 32'h0000_0000;
    localparam logic [31:0] RPC_B = 32'h0000_1000;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        stall_if, stall_id, branch_flag, flush;
    logic [31:0] branch_target, flush_pc;
    logic [31:0] a_addr, a_data, a_idpc, a_inst;
    logic        a_ce, a_valid;
    logic [31:0] b_addr, b_data, b_idpc, b_inst;
    logic        b_ce, b_valid;

    int n_cmp;
    int n_bad;
    in_t     cur;
    mstate_t ma, mb;
    vec_t    vec[21];

    // combinational ROM contents
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h3401_4000;
        if (a == 32'h4) return 32'h0001_0c00;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    assign a_data = rom_word(a_addr);
    assign b_data = rom_word(b_addr);

    fetch_unit #(.RESET_PC(RPC_A), .DELAY_SLOT(1)) dut_a (
        .clk(clk), .rst(rst), .stall_if_i(stall_if), .stall_id_i(stall_id),
        .branch_flag_i(branch_flag), .branch_target_i(branch_target),
        .flush_i(flush), .flush_pc_i(flush_pc), .rom_addr_o(a_addr),
        .rom_ce_o(a_ce), .rom_data_i(a_data), .id_pc_o(a_idpc),
        .id_inst_o(a_inst), .id_valid_o(a_valid)
    );

    fetch_unit #(.RESET_PC(RPC_B), .DELAY_SLOT(0)) dut_b (
        .clk(clk), .rst(rst), .stall_if_i(stall_if), .stall_id_i(stall_id),
        .branch_flag_i(branch_flag), .branch_target_i(branch_target),
        .flush_i(flush), .flush_pc_i(flush_pc), .rom_addr_o(b_addr),
        .rom_ce_o(b_ce), .rom_data_i(b_data), .id_pc_o(b_idpc),
        .id_inst_o(b_inst), .id_valid_o(b_valid)
    );

    // reference model: what the front end holds after reset
    function automatic mstate_t m_reset(input logic [31:0] rpc);
        mstate_t s;
        s.pc = rpc; s.ce = 1'b0; s.id_pc = 32'h0; s.id_inst = 32'h0; s.id_valid = 1'b0;
        return s;
    endfunction

    // reference model: one clock edge, straight from the priority rules
    function automatic mstate_t m_step(input mstate_t s, input in_t x, input bit ds);
        mstate_t n;
        n = s;
        n.ce = 1'b1;
        if (s.ce) begin
            if (x.fl)             n.pc = x.fpc & 32'hFFFF_FFFC;
            else if (x.sif || x.sid) n.pc = s.pc;
            else if (x.br)        n.pc = x.tgt & 32'hFFFF_FFFC;
            else                  n.pc = s.pc + 32'd4;
        end
        if (x.sid && !x.fl) begin
            n.id_pc = s.id_pc; n.id_inst = s.id_inst; n.id_valid = s.id_valid;
        end else if (x.fl || x.sif || !s.ce || (x.br && !ds)) begin
            n.id_pc = s.pc; n.id_inst = 32'h0; n.id_valid = 1'b0;
        end else begin
            n.id_pc = s.pc; n.id_inst = rom_word(s.pc); n.id_valid = 1'b1;
        end
        return n;
    endfunction

    function automatic vec_t mk(input logic sif, input logic sid, input logic br,
                                input logic [31:0] tgt, input logic fl, input logic [31:0] fpc,
                                input logic [31:0] addr, input logic [31:0] idpc,
                                input logic [31:0] inst, input logic valid);
        vec_t v;
        v.in.sif = sif; v.in.sid = sid; v.in.br = br; v.in.tgt = tgt;
        v.in.fl = fl; v.in.fpc = fpc;
        v.e_addr = addr; v.e_idpc = idpc; v.e_inst = inst; v.e_valid = valid;
        return v;
    endfunction

    // driver
    task automatic apply(input in_t x);
        cur           = x;
        stall_if      = x.sif;
        stall_id      = x.sid;
        branch_flag   = x.br;
        branch_target = x.tgt;
        flush         = x.fl;
        flush_pc      = x.fpc;
    endtask

    // scoreboard
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check32("a_rom_addr", a_addr, ma.pc);
        check32("a_rom_ce", {31'h0, a_ce}, {31'h0, ma.ce});
        check32("a_id_pc", a_idpc, ma.id_pc);
        check32("a_id_inst", a_inst, ma.id_inst);
        check32("a_id_valid", {31'h0, a_valid}, {31'h0, ma.id_valid});
        check32("b_rom_addr", b_addr, mb.pc);
        check32("b_rom_ce", {31'h0, b_ce}, {31'h0, mb.ce});
        check32("b_id_pc", b_idpc, mb.id_pc);
        check32("b_id_inst", b_inst, mb.id_inst);
        check32("b_id_valid", {31'h0, b_valid}, {31'h0, mb.id_valid});
    endtask

    // one clock edge, model update, then compare 1 time unit later
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            ma = m_reset(RPC_A);
            mb = m_reset(RPC_B);
        end else begin
            ma = m_step(ma, cur, 1'b1);
            mb = m_step(mb, cur, 1'b0);
        end
        #1;
        check_model();
    endtask

    // asynchronous reset pulse landing mid-cycle
    task automatic reset_pulse();
        #2;
        rst = 1'b1;
        ma = m_reset(RPC_A);
        mb = m_reset(RPC_B);
        #1;
        check_model();
        tick();
        rst = 1'b0;
    endtask

    in_t zero_in;
    in_t rin;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        zero_in = '{sif: 1'b0, sid: 1'b0, br: 1'b0, tgt: 32'h0, fl: 1'b0, fpc: 32'h0};
        rst = 1'b1;
        apply(zero_in);
        ma = m_reset(RPC_A);
        mb = m_reset(RPC_B);

        // directed vectors for instance A, one entry per edge after reset release
        vec[0]  = mk(0,0,0,32'h0,0,32'h0, 32'h0,  32'h0,  32'h0,                  0);
        vec[1]  = mk(0,0,0,32'h0,0,32'h0, 32'h4,  32'h0,  32'h3401_4000,          1);
        vec[2]  = mk(0,0,0,32'h0,0,32'h0, 32'h8,  32'h4,  32'h0001_0c00,          1);
        vec[3]  = mk(0,0,0,32'h0,0,32'h0, 32'hC,  32'h8,  rom_word(32'h8),        1);
        vec[4]  = mk(0,0,0,32'h0,0,32'h0, 32'h10, 32'hC,  rom_word(32'hC),        1);
        vec[5]  = mk(1,1,0,32'h0,0,32'h0, 32'h10, 32'hC,  rom_word(32'hC),        1);
        vec[6]  = mk(1,1,0,32'h0,0,32'h0, 32'h10, 32'hC,  rom_word(32'hC),        1);
        vec[7]  = mk(0,0,0,32'h0,0,32'h0, 32'h14, 32'h10, rom_word(32'h10),       1);
        vec[8]  = mk(1,0,0,32'h0,0,32'h0, 32'h14, 32'h14, 32'h0,                  0);
        vec[9]  = mk(0,0,0,32'h0,0,32'h0, 32'h18, 32'h14, rom_word(32'h14),       1);
        vec[10] = mk(0,0,0,32'h0,0,32'h0, 32'h1C, 32'h18, rom_word(32'h18),       1);
        vec[11] = mk(0,0,0,32'h0,0,32'h0, 32'h20, 32'h1C, rom_word(32'h1C),       1);
        vec[12] = mk(0,0,1,32'h42,0,32'h0, 32'h40, 32'h20, rom_word(32'h20),      1);
        vec[13] = mk(0,0,0,32'h0,0,32'h0, 32'h44, 32'h40, rom_word(32'h40),       1);
        vec[14] = mk(1,0,1,32'h42,1,32'h80, 32'h80, 32'h44, 32'h0,                0);
        vec[15] = mk(0,0,0,32'h0,0,32'h0, 32'h84, 32'h80, rom_word(32'h80),       1);
        vec[16] = mk(0,0,0,32'h0,1,32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h84, 32'h0,   0);
        vec[17] = mk(0,0,0,32'h0,0,32'h0, 32'h0,  32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 1);
        vec[18] = mk(0,0,0,32'h0,0,32'h0, 32'h4,  32'h0,  32'h3401_4000,          1);
        vec[19] = mk(0,1,1,32'h100,0,32'h0, 32'h4, 32'h0, 32'h3401_4000,          1);
        vec[20] = mk(0,0,1,32'h100,0,32'h0, 32'h100, 32'h4, 32'h0001_0c00,        1);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_model();
        check32("rst_a_ce", {31'h0, a_ce}, 32'h0);
        check32("rst_b_addr", b_addr, RPC_B);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            apply(vec[i].in);
            tick();
            check32($sformatf("vec%0d_addr", i), a_addr, vec[i].e_addr);
            check32($sformatf("vec%0d_ce", i), {31'h0, a_ce}, 32'h1);
            check32($sformatf("vec%0d_id_pc", i), a_idpc, vec[i].e_idpc);
            check32($sformatf("vec%0d_id_inst", i), a_inst, vec[i].e_inst);
            check32($sformatf("vec%0d_id_valid", i), {31'h0, a_valid}, {31'h0, vec[i].e_valid});
            if (i == 12) begin
                check32("nods_branch_addr", b_addr, 32'h40);
                check32("nods_branch_valid", {31'h0, b_valid}, 32'h0);
                check32("nods_branch_inst", b_inst, 32'h0);
            end
        end

        // reset while a stall and branch are pending: nothing survives
        rin = zero_in;
        rin.sif = 1'b1; rin.br = 1'b1; rin.tgt = 32'h200;
        apply(rin);
        reset_pulse();
        apply(zero_in);
        tick();
        check32("post_rst_ce", {31'h0, a_ce}, 32'h1);
        check32("post_rst_addr", a_addr, 32'h0);
        check32("post_rst_valid", {31'h0, a_valid}, 32'h0);
        tick();
        check32("post_rst_addr2", a_addr, 32'h4);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rin.sif = ($urandom_range(0, 5) == 0);
            rin.sid = ($urandom_range(0, 7) == 0);
            rin.br  = ($urandom_range(0, 4) == 0);
            rin.tgt = $urandom;
            rin.fl  = ($urandom_range(0, 11) == 0);
            rin.fpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
            apply(rin);
            if ($urandom_range(0, 59) == 0) reset_pulse();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
